// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - sequencing FSM for the 8-bit count-to-10 datapath
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous reset, active low
//   start      run request, sampled only in IDLE
//   abort      returns the FSM to IDLE from any busy state
//   hold       freezes the pacing counter while in PACE
//   ALt10      datapath flag, A register < 10 (sampled only in CHECK)
//   ASrcMuxSel datapath A-source select: 0 = constant 0, 1 = adder result
//   ALoad      datapath A register load enable
//   OutPort    datapath output-port register load enable
//   busy       high in every state except IDLE
//   done       one-cycle pulse on normal completion
//   iter_cnt   OUT states entered since the last INIT (saturates at 255)
//   state_o    current state encoding
module counter_seq_ctrl #(
    parameter int unsigned PACE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
    input  logic       ALt10,
    output logic       ASrcMuxSel,
    output logic       ALoad,
    output logic       OutPort,
    output logic       busy,
    output logic       done,
    output logic [7:0] iter_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_OUT   = 3'd3,
        S_PACE  = 3'd4,
        S_INC   = 3'd5,
        S_DONE  = 3'd6,
        S_BAD   = 3'd7
    } state_t;

    // Terminal value of the pace counter; PACE lasts PACE_CYCLES unheld cycles.
    localparam logic [7:0] PACE_LAST = 8'(PACE_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pace_q;
    logic [7:0] pace_d;
    logic [7:0] iter_q;
    logic [7:0] iter_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pace_q  <= 8'd0;
            iter_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pace_q  <= pace_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pace_d  = pace_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                iter_d  = 8'd0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = ALt10 ? S_OUT : S_DONE;
            end
            S_OUT: begin
                // Counts the OUT visit itself, so it still advances if this
                // cycle is aborted.
                if (iter_q != 8'hFF) begin
                    iter_d = iter_q + 8'd1;
                end
                pace_d  = 8'd0;
                state_d = S_PACE;
            end
            S_PACE: begin
                if (!hold) begin
                    if (pace_q == PACE_LAST) begin
                        state_d = S_INC;
                    end else begin
                        pace_d = pace_q + 8'd1;
                    end
                end
            end
            S_INC: begin
                state_d = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // abort overrides every transition above, including hold and DONE.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Moore outputs: decoded from the state register only.
    always_comb begin
        ASrcMuxSel = 1'b0;
        ALoad      = 1'b0;
        OutPort    = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_INIT: begin
                ALoad = 1'b1;
            end
            S_OUT: begin
                OutPort = 1'b1;
            end
            S_INC: begin
                ASrcMuxSel = 1'b1;
                ALoad      = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign iter_cnt = iter_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - self-checking bench for counter_seq_ctrl
module tb_counter_seq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic hold = 1'b0;

    always #5 clk = ~clk;

    // index 0: PACE_CYCLES=1, index 1: PACE_CYCLES=3
    logic       mux[2];
    logic       aload[2];
    logic       outp[2];
    logic       busy[2];
    logic       done[2];
    logic       alt10[2];
    logic [7:0] iter[2];
    logic [7:0] a_reg[2];
    logic [7:0] port_reg[2];
    logic [2:0] st[2];

    counter_seq_ctrl #(.PACE_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
        .ALt10(alt10[0]), .ASrcMuxSel(mux[0]), .ALoad(aload[0]), .OutPort(outp[0]),
        .busy(busy[0]), .done(done[0]), .iter_cnt(iter[0]), .state_o(st[0])
    );

    counter_seq_ctrl #(.PACE_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
        .ALt10(alt10[1]), .ASrcMuxSel(mux[1]), .ALoad(aload[1]), .OutPort(outp[1]),
        .busy(busy[1]), .done(done[1]), .iter_cnt(iter[1]), .state_o(st[1])
    );

    // count-to-10 datapath, one per controller
    always_comb begin
        for (int i = 0; i < 2; i++) alt10[i] = (a_reg[i] < 8'd10);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                a_reg[i]    <= 8'd0;
                port_reg[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (aload[i]) a_reg[i] <= mux[i] ? a_reg[i] + 8'd1 : 8'd0;
                if (outp[i]) port_reg[i] <= a_reg[i];
            end
        end
    end

    // event log
    int cyc = 0;
    int init_cyc[2];
    int done_cyc[2];
    int done_cnt[2];
    int out_cyc[2][$];
    int cap[2][$];
    bit cap_pend[2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (cap_pend[i]) cap[i].push_back(int'(port_reg[i]));
                cap_pend[i] = outp[i];
                if (st[i] == 3'd1) init_cyc[i] = cyc;
                if (done[i]) begin
                    done_cyc[i] = cyc;
                    done_cnt[i] = done_cnt[i] + 1;
                end
                if (outp[i]) out_cyc[i].push_back(cyc);
            end
        end
    end

    // Reference model: a run is a position t (cycles since INIT, not counting
    // held PACE cycles); the visible phase follows from t by arithmetic.
    function automatic int pval(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [2:0] phase_of(int p, bit run, int t);
        int u, k, r;
        if (!run) return 3'd0;
        if (t == 0) return 3'd1;
        u = t - 1;
        k = u / (p + 3);
        r = u % (p + 3);
        if (k >= 10) return (r == 0) ? 3'd2 : 3'd6;
        if (r == 0) return 3'd2;
        if (r == 1) return 3'd3;
        if (r == p + 2) return 3'd5;
        return 3'd4;
    endfunction

    // {ASrcMuxSel, ALoad, OutPort, busy, done}
    function automatic logic [4:0] exp_ctrl(logic [2:0] ph);
        case (ph)
            3'd1:    return 5'b01010;
            3'd2:    return 5'b00010;
            3'd3:    return 5'b00110;
            3'd4:    return 5'b00010;
            3'd5:    return 5'b11010;
            3'd6:    return 5'b00011;
            default: return 5'b00000;
        endcase
    endfunction

    bit m_run[2];
    int m_t[2];
    int m_iter[2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_iter[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_run[i]) begin
                    if (start) begin
                        m_run[i] <= 1'b1;
                        m_t[i]   <= 0;
                    end
                end else begin
                    if (phase_of(pval(i), m_run[i], m_t[i]) == 3'd1) m_iter[i] <= 0;
                    if (phase_of(pval(i), m_run[i], m_t[i]) == 3'd3 && m_iter[i] != 255)
                        m_iter[i] <= m_iter[i] + 1;
                    if (abort || phase_of(pval(i), m_run[i], m_t[i]) == 3'd6)
                        m_run[i] <= 1'b0;
                    else if (!(phase_of(pval(i), m_run[i], m_t[i]) == 3'd4 && hold))
                        m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic logic [4:0] ctrl_of(int i);
        return {mux[i], aload[i], outp[i], busy[i], done[i]};
    endfunction

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            out_cyc[i].delete();
            cap[i].delete();
            cap_pend[i] = 1'b0;
            init_cyc[i] = -1000;
            done_cyc[i] = -1000;
            done_cnt[i] = 0;
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_logs();
        reset = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(int i, logic [2:0] s, int lim, string nm);
        for (int n = 0; n < lim && st[i] !== s; n++) @(negedge clk);
        check(nm, 32'(st[i]), 32'(s));
    endtask

    // Checks a completed run: done count, INIT->DONE length, captured values
    // 0..9 and OutPort spacing (one interval may be stretched by extra).
    task automatic check_run(int i, string nm, int exp_len, int stretch_k, int extra);
        check({nm, "_done_cnt"}, 32'(done_cnt[i]), 32'd1);
        check({nm, "_len"}, 32'(done_cyc[i] - init_cyc[i]), 32'(exp_len));
        check({nm, "_ncap"}, 32'(cap[i].size()), 32'd10);
        check({nm, "_nout"}, 32'(out_cyc[i].size()), 32'd10);
        if (cap[i].size() == 10) begin
            for (int k = 0; k < 10; k++) check({nm, "_cap"}, 32'(cap[i][k]), 32'(k));
        end
        if (out_cyc[i].size() == 10) begin
            for (int k = 1; k < 10; k++)
                check({nm, "_gap"}, 32'(out_cyc[i][k] - out_cyc[i][k-1]),
                      32'(pval(i) + 3 + ((k == stretch_k) ? extra : 0)));
        end
        check({nm, "_iter"}, 32'(iter[i]), 32'd10);
        check({nm, "_a"}, 32'(a_reg[i]), 32'd10);
    endtask

    typedef struct {
        bit         s;
        bit         a;
        bit         h;
        logic [2:0] st;
        logic [7:0] it;
    } vec_t;

    vec_t vecs[14];
    logic [2:0] ph;
    int n;

    initial begin
        // inputs applied before an edge, expected PACE_CYCLES=3 state after it
        vecs[0]  = '{0, 0, 0, 3'd0, 8'd0};
        vecs[1]  = '{1, 0, 0, 3'd1, 8'd0};
        vecs[2]  = '{0, 0, 0, 3'd2, 8'd0};
        vecs[3]  = '{0, 0, 0, 3'd3, 8'd0};
        vecs[4]  = '{0, 0, 0, 3'd4, 8'd1};
        vecs[5]  = '{0, 0, 1, 3'd4, 8'd1};
        vecs[6]  = '{0, 0, 0, 3'd4, 8'd1};
        vecs[7]  = '{0, 0, 0, 3'd4, 8'd1};
        vecs[8]  = '{0, 0, 0, 3'd5, 8'd1};
        vecs[9]  = '{0, 0, 0, 3'd2, 8'd1};
        vecs[10] = '{0, 1, 0, 3'd0, 8'd1};
        vecs[11] = '{0, 0, 1, 3'd0, 8'd1};
        vecs[12] = '{1, 0, 0, 3'd1, 8'd1};
        vecs[13] = '{0, 0, 0, 3'd2, 8'd0};

        do_reset();
        check("reset_state", 32'(st[1]), 32'd0);
        check("reset_ctrl", 32'(ctrl_of(1)), 32'd0);
        for (int r = 0; r < 14; r++) begin
            start = vecs[r].s;
            abort = vecs[r].a;
            hold  = vecs[r].h;
            @(negedge clk);
            check($sformatf("vec%0d_state", r), 32'(st[1]), 32'(vecs[r].st));
            check($sformatf("vec%0d_ctrl", r), 32'(ctrl_of(1)), 32'(exp_ctrl(vecs[r].st)));
            check($sformatf("vec%0d_iter", r), 32'(iter[1]), 32'(vecs[r].it));
        end

        // asynchronous reset in the middle of PACE
        do_reset();
        pulse_start();
        wait_state(1, 3'd4, 20, "t1_reach_pace");
        #2 reset = 1'b0;
        #1;
        check("t1_async_state", 32'(st[1]), 32'd0);
        check("t1_async_ctrl", 32'(ctrl_of(1)), 32'd0);
        check("t1_async_iter", 32'(iter[1]), 32'd0);
        check("t1_async_ctrl_a", 32'(ctrl_of(0)), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t1_idle_after", 32'(st[1]), 32'd0);
        check("t1_idle_busy", 32'(busy[1]), 32'd0);

        // full runs, PACE_CYCLES=1 and 3 side by side
        do_reset();
        pulse_start();
        wait_state(1, 3'd6, 200, "t23_reach_done");
        repeat (3) @(negedge clk);
        check_run(0, "t2", 42, 0, 0);
        check_run(1, "t3", 62, 0, 0);

        // hold for 5 cycles during the 4th PACE
        do_reset();
        pulse_start();
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (outp[1]) n++;
            if (n == 4 && st[1] == 3'd4) break;
            @(negedge clk);
        end
        check("t4_reach_pace4", 32'(st[1]), 32'd4);
        hold = 1'b1;
        repeat (5) @(negedge clk);
        hold = 1'b0;
        wait_state(1, 3'd6, 200, "t4_reach_done");
        repeat (3) @(negedge clk);
        check_run(1, "t4", 67, 4, 5);

        // abort in the INC after value 4
        do_reset();
        pulse_start();
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (outp[1]) n++;
            if (n == 5 && st[1] == 3'd5) break;
            @(negedge clk);
        end
        check("t5_reach_inc", 32'(st[1]), 32'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_idle", 32'(st[1]), 32'd0);
        repeat (5) @(negedge clk);
        check("t5_no_done", 32'(done_cnt[1]), 32'd0);
        check("t5_iter", 32'(iter[1]), 32'd5);
        clear_logs();
        pulse_start();
        for (int c = 0; c < 40 && cap[1].size() == 0; c++) @(negedge clk);
        check("t5_restart_ncap", 32'(cap[1].size() > 0), 32'd1);
        if (cap[1].size() > 0) check("t5_restart_cap0", 32'(cap[1][0]), 32'd0);

        // start held high, abort together with DONE
        do_reset();
        start = 1'b1;
        wait_state(1, 3'd6, 200, "t6_reach_done");
        check("t6_done", 32'(done[1]), 32'd1);
        check("t6_iter_done", 32'(iter[1]), 32'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_idle", 32'(st[1]), 32'd0);
        check("t6_idle_busy", 32'(busy[1]), 32'd0);
        @(negedge clk);
        check("t6_reinit", 32'(st[1]), 32'd1);
        @(negedge clk);
        check("t6_check", 32'(st[1]), 32'd2);
        check("t6_iter_clr", 32'(iter[1]), 32'd0);
        start = 1'b0;

        // randomized run against the reference model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                ph = phase_of(pval(i), m_run[i], m_t[i]);
                check($sformatf("rnd%0d_cyc%0d", i, c),
                      32'({st[i], ctrl_of(i), iter[i]}),
                      32'({ph, exp_ctrl(ph), 8'(m_iter[i])}));
            end
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 99) == 0);
            hold  = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
